bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised N-digit BCD up/down counter core with a run/stop state machine, button-edge command decoding, load, and wrap or saturate end-of-range handling. Sits between the debounce stage and the FND display controller. Consumes the shared 1 kHz `tick` enable and debounced button levels, and drives packed BCD digits plus status flags.

## Interface
- `DIGITS`, 4: number of BCD digits, 1–8.
- `STEP_TICKS`, 100: `tick` pulses per count step while running, ≥1.
- `WRAP`, 1: 1 = wrap at the range ends; 0 = saturate and stop.
- `clk_100Mhz` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle enable strobe from the tick generator.
- `btnDb` in 3: debounced levels. [0] = run/stop toggle, [1] = direction toggle, [2] = clear.
- `load` in 1: level; its rising edge loads `loadVal`.
- `loadVal` in 4*DIGITS: BCD load value, digit 0 in bits [3:0].
- `bcd` out 4*DIGITS: count value, digit 0 = least significant.
- `running` out 1: high in state RUN.
- `dirDown` out 1: 0 = count up, 1 = count down.
- `endPulse` out 1: one-cycle pulse when the count wraps or saturates.

## Operation
- Edge detect: `btnDb` and `load` are registered every clock. An event is `cur & ~prev`. A held input produces exactly one event, with no auto-repeat.
- FSM states and transitions:
  - STOP → RUN on a run/stop event.
  - RUN → STOP on a run/stop event.
  - RUN → STOP on saturation when WRAP=0.
  - Clear and load never change the state.
- Step divider: a counter in the range 0..STEP_TICKS-1.
  - It advances only on `tick` while in RUN.
  - A step fires on a cycle with `tick`=1, state RUN and divider = STEP_TICKS-1. The divider then returns to 0.
  - The divider is forced to 0 on clear, on load, and on the STOP→RUN transition.
- Stepping uses BCD arithmetic per digit with ripple borrow/carry.
  - Up: a digit at 9 becomes 0 and carries into the next digit.
  - Down: a digit at 0 becomes 9 and borrows from the next digit.
- Upper end (all digits 9), stepping up:
  - WRAP=1: count becomes 0 and `endPulse` fires.
  - WRAP=0: count holds, `endPulse` fires, state goes to STOP.
- Lower end (count 0), stepping down:
  - WRAP=1: count becomes all 9s and `endPulse` fires.
  - WRAP=0: count holds at 0, `endPulse` fires, state goes to STOP.
- Direction event: toggles `dirDown` in either state. The count is unchanged.
- Clear event: sets `bcd` to 0. State and `dirDown` are kept.
- Load event: `bcd` takes `loadVal`. Any digit > 9 is clamped to 9.
- Priority when events share a cycle: clear > load > run/stop > direction > step.
  - Clear or load in the same cycle as a step suppresses the step.
  - Run/stop and direction events are still applied in that cycle.
- A direction event coincident with a step: the step uses the old direction, and the new direction applies from the next step.

## Timing
- Reset values (asynchronous assert): `bcd`=0, state STOP, `running`=0, `dirDown`=0, `endPulse`=0, divider 0, edge registers 0.
- Reset release: the first event can be detected on the first clock after `rst` goes high. An input already high at release counts as an event, because the edge registers reset to 0.
- Reset asserted mid-operation: all registers return to their reset values immediately, with no clock required.
- Event latency: an input first sampled high at clock edge k has its effect visible on the outputs after edge k+1 (one register stage).
- Step latency: `bcd` updates at the clock edge where the step condition is true.
  - `endPulse` is high for exactly that following cycle.
  - With WRAP=0, `running` falls in the same cycle as `endPulse`.
- Step period in RUN: exactly STEP_TICKS `tick` pulses between consecutive steps. The first step after entering RUN occurs on the STEP_TICKS-th tick.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Bench settings for all cases: DIGITS=4, STEP_TICKS=2, tick every 10 clocks.
- Basic counting: reset, press run → `running`=1 next cycle; after 2 ticks `bcd`=0x0001, after 20 ticks `bcd`=0x0010 (carry from digit 0 into digit 1).
- Wrap, WRAP=1: load 0x9999, run, up → next step gives `bcd`=0x0000 with a one-cycle `endPulse`. Toggle direction, step → `bcd`=0x9999 with `endPulse`.
- Saturate, WRAP=0: load 0x0001, dirDown=1, run → steps to 0x0000. The next step holds 0x0000, pulses `endPulse` and drops `running` in the same cycle.
- Priority and clamp:
  - Clear and load events in the same cycle → `bcd`=0.
  - Load 0xF3A9 → `bcd`=0x9399.
  - Load coincident with a step → the step is suppressed.
  - Button held for 50 cycles → exactly one toggle.
- Reset mid-run: assert `rst` low while at 0x0123, RUN, down → all outputs return to their reset values asynchronously. After release, stepping is held until a run event.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit BCD up/down counter with run/stop FSM, edge-decoded buttons,
// clamped load and wrap or saturate handling at the range ends.
module bcd_updown_counter #(
   parameter int DIGITS     = 4,
   parameter int STEP_TICKS = 100,
   parameter bit WRAP       = 1'b1
) (
   input  logic                clk_100Mhz,
   input  logic                rst,
   input  logic                tick,
   input  logic [2:0]          btnDb,
   input  logic                load,
   input  logic [4*DIGITS-1:0] loadVal,
   output logic [4*DIGITS-1:0] bcd,
   output logic                running,
   output logic                dirDown,
   output logic                endPulse
);
   localparam int DW = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
   localparam int W  = 4 * DIGITS;
   typedef enum logic {STOP, RUN} state_t;
   state_t state;
   logic [2:0] btn_cur, btn_prev;
   logic load_cur, load_prev;
   logic [DW-1:0] div;
   logic [W-1:0] stepped, clamped;
   logic ripple, at_end, run_ev, dir_ev, clr_ev, load_ev, div_last, step, saturate;
   assign {clr_ev, dir_ev, run_ev} = btn_cur & ~btn_prev;
   assign load_ev  = load_cur & ~load_prev;
   assign div_last = div == DW'(STEP_TICKS - 1);
   assign step     = tick && state == RUN && div_last && !clr_ev && !load_ev;
   assign saturate = step && at_end && !WRAP;
   // a carry or borrow rippling out of the top digit marks the range end
   always_comb begin
      ripple  = 1'b1;
      stepped = bcd;
      clamped = loadVal;
      for (int i = 0; i < DIGITS; i++) begin
         if (ripple)
            stepped[4*i+:4] = dirDown ? (bcd[4*i+:4] == 4'd0 ? 4'd9 : bcd[4*i+:4] - 4'd1)
                                      : (bcd[4*i+:4] == 4'd9 ? 4'd0 : bcd[4*i+:4] + 4'd1);
         ripple = ripple && bcd[4*i+:4] == (dirDown ? 4'd0 : 4'd9);
         clamped[4*i+:4] = loadVal[4*i+:4] > 4'd9 ? 4'd9 : loadVal[4*i+:4];
      end
      at_end = ripple;
   end
   always_ff @(posedge clk_100Mhz or negedge rst) begin
      if (!rst) begin
         btn_cur   <= '0;
         btn_prev  <= '0;
         load_cur  <= 1'b0;
         load_prev <= 1'b0;
         state     <= STOP;
         running   <= 1'b0;
         dirDown   <= 1'b0;
         endPulse  <= 1'b0;
         div       <= '0;
         bcd       <= '0;
      end else begin
         btn_cur   <= btnDb;
         btn_prev  <= btn_cur;
         load_cur  <= load;
         load_prev <= load_cur;
         endPulse  <= step && at_end;
         if (clr_ev)
            bcd <= '0;
         else if (load_ev)
            bcd <= clamped;
         else if (step && !saturate)
            bcd <= stepped;
         if (run_ev) begin
            state   <= state == RUN ? STOP : RUN;
            running <= state != RUN;
         end else if (saturate) begin
            state   <= STOP;
            running <= 1'b0;
         end
         if (dir_ev)
            dirDown <= !dirDown;
         if (clr_ev || load_ev || (run_ev && state == STOP))
            div <= '0;
         else if (tick && state == RUN)
            div <= div_last ? '0 : div + DW'(1);
      end
   end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed checks of a wrapping and a saturating counter instance.
module tb_bcd_updown_counter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic tick = 1'b0;
   logic [2:0] btn = '0;
   logic load = 1'b0;
   logic [15:0] lv = '0;
   logic sel = 1'b0;
   logic [15:0] bcd_a, bcd_b;
   logic run_a, run_b, dir_a, dir_b, end_a, end_b;
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(4), .STEP_TICKS(2), .WRAP(1'b1)) dut_w (
      .clk_100Mhz(clk), .rst(rst_n), .tick(tick),
      .btnDb(sel ? 3'b000 : btn), .load(sel ? 1'b0 : load), .loadVal(lv),
      .bcd(bcd_a), .running(run_a), .dirDown(dir_a), .endPulse(end_a));

   bcd_updown_counter #(.DIGITS(4), .STEP_TICKS(2), .WRAP(1'b0)) dut_s (
      .clk_100Mhz(clk), .rst(rst_n), .tick(tick),
      .btnDb(sel ? btn : 3'b000), .load(sel ? load : 1'b0), .loadVal(lv),
      .bcd(bcd_b), .running(run_b), .dirDown(dir_b), .endPulse(end_b));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int b);
      btn[b] = 1'b1;
      cyc(2);
      btn[b] = 1'b0;
      cyc(1);
   endtask

   task automatic press_load();
      load = 1'b1;
      cyc(2);
      load = 1'b0;
      cyc(1);
   endtask

   task automatic pulse();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         pulse();
         cyc(9);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      cyc(2);
      check("rst_bcd", bcd_a, 16'h0000);
      check("rst_run", 16'(run_a), 16'd0);
      check("rst_dir", 16'(dir_a), 16'd0);
      check("rst_end", 16'(end_a), 16'd0);
      rst_n = 1'b1;
      cyc(1);
      // basic counting with carry
      press(0);
      check("run_on", 16'(run_a), 16'd1);
      ticks(2);
      check("count_1", bcd_a, 16'h0001);
      ticks(18);
      check("count_10", bcd_a, 16'h0010);
      // wrap at both ends
      press(0);
      check("run_off", 16'(run_a), 16'd0);
      lv = 16'h9999;
      press_load();
      check("load_9999", bcd_a, 16'h9999);
      press(0);
      ticks(1);
      pulse();
      check("wrap_up_bcd", bcd_a, 16'h0000);
      check("wrap_up_end", 16'(end_a), 16'd1);
      cyc(1);
      check("wrap_up_end_low", 16'(end_a), 16'd0);
      cyc(8);
      press(1);
      check("dir_down", 16'(dir_a), 16'd1);
      ticks(1);
      pulse();
      check("wrap_dn_bcd", bcd_a, 16'h9999);
      check("wrap_dn_end", 16'(end_a), 16'd1);
      cyc(9);
      // priority and clamp
      lv = 16'h1234;
      btn[2] = 1'b1;
      load = 1'b1;
      cyc(2);
      btn[2] = 1'b0;
      load = 1'b0;
      cyc(1);
      check("clr_over_load", bcd_a, 16'h0000);
      lv = 16'hF3A9;
      press_load();
      check("clamp", bcd_a, 16'h9399);
      ticks(1);
      lv = 16'h0555;
      load = 1'b1;
      cyc(1);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      load = 1'b0;
      check("load_supp_step", bcd_a, 16'h0555);
      check("load_supp_end", 16'(end_a), 16'd0);
      cyc(9);
      ticks(2);
      check("step_after_load", bcd_a, 16'h0554);
      btn[1] = 1'b1;
      cyc(50);
      btn[1] = 1'b0;
      cyc(2);
      check("held_one_toggle", 16'(dir_a), 16'd0);
      check("held_bcd", bcd_a, 16'h0554);
      ticks(1);
      btn[1] = 1'b1;
      cyc(1);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      btn[1] = 1'b0;
      check("dir_step_old", bcd_a, 16'h0555);
      check("dir_step_new", 16'(dir_a), 16'd1);
      cyc(9);
      // asynchronous reset mid-run
      lv = 16'h0123;
      press_load();
      check("pre_rst_bcd", bcd_a, 16'h0123);
      #2 rst_n = 1'b0;
      #1;
      check("arst_bcd", bcd_a, 16'h0000);
      check("arst_run", 16'(run_a), 16'd0);
      check("arst_dir", 16'(dir_a), 16'd0);
      check("arst_end", 16'(end_a), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);
      ticks(4);
      check("held_after_rst", bcd_a, 16'h0000);
      check("stopped_after_rst", 16'(run_a), 16'd0);
      press(0);
      ticks(2);
      check("restart_count", bcd_a, 16'h0001);
      // saturating instance
      sel = 1'b1;
      lv = 16'h0001;
      press_load();
      check("sat_load", bcd_b, 16'h0001);
      press(1);
      check("sat_dir", 16'(dir_b), 16'd1);
      press(0);
      check("sat_run", 16'(run_b), 16'd1);
      ticks(2);
      check("sat_zero", bcd_b, 16'h0000);
      check("sat_still_run", 16'(run_b), 16'd1);
      ticks(1);
      pulse();
      check("sat_hold", bcd_b, 16'h0000);
      check("sat_end", 16'(end_b), 16'd1);
      check("sat_stop", 16'(run_b), 16'd0);
      cyc(1);
      check("sat_end_low", 16'(end_b), 16'd0);
      cyc(8);
      ticks(2);
      check("sat_idle_bcd", bcd_b, 16'h0000);
      check("sat_idle_run", 16'(run_b), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
